alu_ctrl_pipe: RTL and testbench
================================

Name: alu_ctrl_pipe

Overview:
Parametrised, registered ALU-control decoder for the 8-bit RISC-V pipeline. It sits at the ID/EX boundary and turns {alu_op, funct7, funct3} into an EX-stage ALU control word. It adds a valid/ready handshake, stall and flush handling, shift decodes, and a multi-cycle MUL sequencer that back-pressures the decode stage.

Parameters:
CTRL_W, 4, width of alu_control (≥4; codes zero-extended when wider)
MUL_CYCLES, 4, EX cycles a MUL occupies (≥1)
ENABLE_MUL, 1, 1 = decode MUL; 0 = MUL funct treated as illegal
CNT_W, $clog2(MUL_CYCLES)+1, width of MUL countdown counter (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode stage presents an instruction
in_ready  out  1  block accepts the instruction this cycle (combinational)
alu_op  in  2  main-control ALU op class
funct  in  10  {funct7[9:3], funct3[2:0]}
stall  in  1  downstream hold; freezes all state
flush  in  1  branch/jump squash; kills the registered op
out_valid  out  1  alu_control holds a live op
alu_control  out  CTRL_W  ALU operation code
illegal  out  1  registered op had an undecodable funct
mul_busy  out  1  EX must not retire the op this cycle (MUL in progress)

Behaviour:
- Codes: AND=0000, OR=0001, ADD=0010, XOR=0011, NOT=0100, SUB=0110, MUL=0111, SLL=1000, SRL=1001, JUMP=1100.
- alu_op decode: 00→ADD; 01→SUB; 11→JUMP (funct ignored); 10→funct table.
- funct table: 0000000_000 ADD, 0100000_000 SUB, 0000000_111 AND, 0000000_110 OR, 0000000_100 XOR, 0000000_011 NOT, 0000000_001 SLL, 0000000_101 SRL, 0000001_000 MUL (only if ENABLE_MUL=1).
- Any other funct with alu_op=10 → AND, illegal=1.
- Reset: out_valid=0, alu_control=ADD, illegal=0, mul_busy=0, cnt=0. in_ready=0 while reset is high.
- in_ready = !reset && !stall && !flush && (cnt==0).
- Accept when in_valid && in_ready. Latency 1: next edge gives out_valid=1, alu_control=decode, illegal=decode flag.
- Accepting a MUL loads cnt=MUL_CYCLES-1. Otherwise cnt stays 0.
- mul_busy = (cnt!=0) && out_valid. This is a registered-state-derived output, not a separate flop.
- While cnt!=0 and !stall: cnt decrements each cycle; alu_control and out_valid hold the MUL; in_ready=0.
- The cycle with cnt==0 and out_valid=1 is the retire cycle. A new op may be accepted in that same cycle, giving back-to-back issue.
- MUL_CYCLES=1: MUL behaves as a single-cycle op and mul_busy never asserts.
- If in_ready=1 and in_valid=0: next edge out_valid=0 (bubble), alu_control=ADD, illegal=0.
- stall=1 (no flush): every register holds, including the counter.
- flush=1: next edge out_valid=0, alu_control=ADD, illegal=0, cnt=0, any MUL is aborted. Any in_valid that cycle is dropped.
- Priority: reset > flush > stall > accept/advance.
- Wider CTRL_W: upper bits are always 0.

Test Plan:
- Reset high 2 cycles, then low with in_valid=0 → out_valid=0, alu_control=0010, in_ready=1.
- Back-to-back alu_op=10 with funct 0000000_000, 0100000_000, 0000000_100, 0000000_101 → next cycles out_valid=1, alu_control 0010, 0110, 0011, 1001; in_ready stays 1.
- MUL (alu_op=10, funct 0000001_000) with MUL_CYCLES=4, then ADD held on in_valid:
  - mul_busy=1 for 3 cycles with alu_control=0111 and in_ready=0.
  - 4th cycle: mul_busy=0, in_ready=1; ADD registers on the following edge.
- MUL with stall=1 for 2 cycles mid-count → counter frozen; total busy span 3+2=5 cycles; outputs unchanged during stall.
- MUL, then flush=1 on busy cycle 2 → next edge out_valid=0, alu_control=0010, mul_busy=0, in_ready=1. Also flush and stall asserted together → flush wins.
- alu_op=10, funct=1111111_111 → alu_control=0000, illegal=1. alu_op=11 with any funct → 1100, illegal=0. ENABLE_MUL=0 with MUL funct → 0000, illegal=1, mul_busy never asserts.

Source files
------------

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe
//   Registered ALU-control decoder at the ID/EX boundary. Turns
//   {alu_op, funct7, funct3} into an EX-stage ALU control word.
//   It provides the following features:
//     - a valid/ready handshake with the decode stage
//     - stall and flush handling
//     - a multi-cycle MUL sequencer that back-pressures the decode stage
//
// Parameters
//   CTRL_W     : width of alu_control (>=4, codes zero-extended)
//   MUL_CYCLES : EX cycles a MUL occupies (>=1)
//   ENABLE_MUL : 1 = decode MUL, 0 = MUL funct is illegal
//
// Ports
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   in_valid    : decode stage presents an instruction
//   in_ready    : instruction accepted this cycle (combinational)
//   alu_op      : main-control op class
//   funct       : {funct7, funct3}
//   stall       : downstream hold, freezes all state
//   flush       : squash the registered op and abort any MUL
//   out_valid   : alu_control holds a live op
//   alu_control : ALU operation code
//   illegal     : registered op had an undecodable funct
//   mul_busy    : MUL still in progress, EX must not retire it
module alu_ctrl_pipe #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int ENABLE_MUL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [9:0]        funct,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] alu_control,
  output logic              illegal,
  output logic              mul_busy
);

  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_NOT  = 4'b0100,
    OP_SUB  = 4'b0110,
    OP_MUL  = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_JUMP = 4'b1100
  } alu_code_e;

  // Registered state
  logic             out_valid_q, out_valid_d;
  alu_code_e        ctrl_q, ctrl_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational decode of the presented instruction
  alu_code_e dec_code;
  logic      dec_illegal;
  logic      dec_mul;

  always_comb begin
    dec_code    = OP_AND;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    unique case (alu_op)
      2'b00: dec_code = OP_ADD;
      2'b01: dec_code = OP_SUB;
      2'b11: dec_code = OP_JUMP;
      default: begin
        case (funct)
          10'b0000000_000: dec_code = OP_ADD;
          10'b0100000_000: dec_code = OP_SUB;
          10'b0000000_111: dec_code = OP_AND;
          10'b0000000_110: dec_code = OP_OR;
          10'b0000000_100: dec_code = OP_XOR;
          10'b0000000_011: dec_code = OP_NOT;
          10'b0000000_001: dec_code = OP_SLL;
          10'b0000000_101: dec_code = OP_SRL;
          10'b0000001_000: begin
            if (ENABLE_MUL != 0) begin
              dec_code = OP_MUL;
              dec_mul  = 1'b1;
            end else begin
              dec_illegal = 1'b1;
            end
          end
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Handshake: only accept when idle or on the retire cycle of a MUL
  assign in_ready = !reset && !stall && !flush && (cnt_q == '0);

  // Next-state: flush > stall > MUL countdown > accept / bubble
  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
      ctrl_d      = OP_ADD;
      illegal_d   = 1'b0;
      cnt_d       = '0;
    end else if (stall) begin
      // hold everything
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      ctrl_d      = dec_code;
      illegal_d   = dec_illegal;
      // The accept edge is the first MUL cycle, so MUL_CYCLES-1 remain.
      cnt_d       = dec_mul ? CNT_W'(MUL_CYCLES - 1) : '0;
    end else begin
      out_valid_d = 1'b0;
      ctrl_d      = OP_ADD;
      illegal_d   = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= OP_ADD;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_control = CTRL_W'(ctrl_q);
  assign illegal     = illegal_q;
  assign mul_busy    = (cnt_q != '0) && out_valid_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
module tb_alu_ctrl_pipe;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [1:0] alu_op;
  logic [9:0] funct;
  logic       stall;
  logic       flush;

  logic       in_ready,  out_valid,  illegal,  mul_busy;
  logic [3:0] alu_control;
  logic       in_ready_b, out_valid_b, illegal_b, mul_busy_b;
  logic [5:0] alu_control_b;
  logic       in_ready_c, out_valid_c, illegal_c, mul_busy_c;
  logic [3:0] alu_control_c;

  alu_ctrl_pipe #(.CTRL_W(4), .MUL_CYCLES(4), .ENABLE_MUL(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .stall(stall), .flush(flush),
    .out_valid(out_valid), .alu_control(alu_control), .illegal(illegal),
    .mul_busy(mul_busy)
  );

  alu_ctrl_pipe #(.CTRL_W(6), .MUL_CYCLES(4), .ENABLE_MUL(0)) dut_nomul (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .alu_op(alu_op), .funct(funct), .stall(stall), .flush(flush),
    .out_valid(out_valid_b), .alu_control(alu_control_b), .illegal(illegal_b),
    .mul_busy(mul_busy_b)
  );

  alu_ctrl_pipe #(.CTRL_W(4), .MUL_CYCLES(1), .ENABLE_MUL(1)) dut_mul1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c),
    .alu_op(alu_op), .funct(funct), .stall(stall), .flush(flush),
    .out_valid(out_valid_c), .alu_control(alu_control_c), .illegal(illegal_c),
    .mul_busy(mul_busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  localparam logic [9:0] F_ADD = 10'b0000000_000;
  localparam logic [9:0] F_SUB = 10'b0100000_000;
  localparam logic [9:0] F_AND = 10'b0000000_111;
  localparam logic [9:0] F_OR  = 10'b0000000_110;
  localparam logic [9:0] F_XOR = 10'b0000000_100;
  localparam logic [9:0] F_NOT = 10'b0000000_011;
  localparam logic [9:0] F_SLL = 10'b0000000_001;
  localparam logic [9:0] F_SRL = 10'b0000000_101;
  localparam logic [9:0] F_MUL = 10'b0000001_000;

  // Reference decode for the 4-cycle, MUL-enabled instance
  function automatic void ref_dec(input logic [1:0] op, input logic [9:0] f,
                                  output logic [3:0] c, output logic ill, output bit is_mul);
    c = 4'b0000; ill = 1'b0; is_mul = 1'b0;
    if (op == 2'b00) c = 4'b0010;
    else if (op == 2'b01) c = 4'b0110;
    else if (op == 2'b11) c = 4'b1100;
    else begin
      if      (f == F_ADD) c = 4'b0010;
      else if (f == F_SUB) c = 4'b0110;
      else if (f == F_AND) c = 4'b0000;
      else if (f == F_OR)  c = 4'b0001;
      else if (f == F_XOR) c = 4'b0011;
      else if (f == F_NOT) c = 4'b0100;
      else if (f == F_SLL) c = 4'b1000;
      else if (f == F_SRL) c = 4'b1001;
      else if (f == F_MUL) begin c = 4'b0111; is_mul = 1'b1; end
      else ill = 1'b1;
    end
  endfunction

  // Expected-state tracking for the main instance
  logic       m_valid;
  logic [3:0] m_ctrl;
  logic       m_ill;
  int         m_cnt;
  logic [4:0] sb[$];

  task automatic cycle(input logic v, input logic [1:0] op, input logic [9:0] f,
                       input logic st, input logic fl);
    logic [3:0] c;
    logic       il;
    bit         ism;
    bit         pending;
    logic [4:0] e;
    in_valid = v; alu_op = op; funct = f; stall = st; flush = fl;
    #1;
    check("in_ready",    in_ready, !st && !fl && (m_cnt == 0));
    check("out_valid",   out_valid, m_valid);
    check("alu_control", alu_control, m_ctrl);
    check("illegal",     illegal, m_ill);
    check("mul_busy",    mul_busy, m_valid && (m_cnt != 0));
    check("nomul_busy",  mul_busy_b, 1'b0);
    check("nomul_upper", alu_control_b[5:4], 2'b00);
    check("mul1_busy",   mul_busy_c, 1'b0);
    pending = 1'b0;
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0; m_ctrl = 4'b0010; m_ill = 1'b0; m_cnt = 0;
    end else if (st) begin
    end else if (m_cnt != 0) begin
      m_cnt--;
    end else if (v) begin
      ref_dec(op, f, c, il, ism);
      sb.push_back({il, c});
      pending = 1'b1;
      m_valid = 1'b1;
      m_cnt = ism ? 3 : 0;
    end else begin
      m_valid = 1'b0; m_ctrl = 4'b0010; m_ill = 1'b0;
    end
    #1;
    if (pending) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_alu_control", alu_control, e[3:0]);
        check("sb_illegal",     illegal, e[4]);
        check("sb_out_valid",   out_valid, 1'b1);
        m_ctrl = e[3:0];
        m_ill  = e[4];
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 2'b00, 10'h000, 1'b0, 1'b0);
  endtask

  logic [9:0] ftab [0:9];

  initial begin
    ftab[0] = F_ADD; ftab[1] = F_SUB; ftab[2] = F_AND; ftab[3] = F_OR;
    ftab[4] = F_XOR; ftab[5] = F_NOT; ftab[6] = F_SLL; ftab[7] = F_SRL;
    ftab[8] = F_MUL; ftab[9] = 10'b1111111_111;

    reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = '0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",    in_ready, 1'b0);
    check("rst_out_valid",   out_valid, 1'b0);
    check("rst_alu_control", alu_control, 4'b0010);
    check("rst_illegal",     illegal, 1'b0);
    check("rst_mul_busy",    mul_busy, 1'b0);
    reset = 1'b0;
    m_valid = 1'b0; m_ctrl = 4'b0010; m_ill = 1'b0; m_cnt = 0;

    idle(1);

    // back-to-back R-type
    cycle(1'b1, 2'b10, F_ADD, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, F_SUB, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, F_XOR, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, F_SRL, 1'b0, 1'b0);
    check("srl_code", alu_control, 4'b1001);
    idle(1);

    // MUL then an ADD held on in_valid until accepted
    cycle(1'b1, 2'b10, F_MUL, 1'b0, 1'b0);
    check("mul_code", alu_control, 4'b0111);
    check("mul_busy1", mul_busy, 1'b1);
    repeat (4) cycle(1'b1, 2'b00, F_ADD, 1'b0, 1'b0);
    check("add_after_mul", alu_control, 4'b0010);
    check("add_after_mul_busy", mul_busy, 1'b0);
    idle(1);

    // MUL with a 2-cycle stall mid-count
    cycle(1'b1, 2'b10, F_MUL, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, F_ADD, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, F_ADD, 1'b1, 1'b0);
    cycle(1'b0, 2'b00, F_ADD, 1'b1, 1'b0);
    check("stall_hold_busy", mul_busy, 1'b1);
    idle(4);

    // MUL flushed on busy cycle 2
    cycle(1'b1, 2'b10, F_MUL, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, F_ADD, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, F_ADD, 1'b0, 1'b1);
    check("flush_valid", out_valid, 1'b0);
    idle(1);
    // flush and stall together: flush wins
    cycle(1'b1, 2'b10, F_MUL, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, F_ADD, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, F_ADD, 1'b1, 1'b1);
    check("flush_stall_busy", mul_busy, 1'b0);
    idle(1);

    // illegal funct and JUMP
    cycle(1'b1, 2'b10, 10'b1111111_111, 1'b0, 1'b0);
    check("illegal_flag", illegal, 1'b1);
    cycle(1'b1, 2'b11, 10'b1010101_010, 1'b0, 1'b0);
    check("jump_code", alu_control, 4'b1100);
    idle(1);

    // MUL on the variant instances
    cycle(1'b1, 2'b10, F_MUL, 1'b0, 1'b0);
    check("nomul_valid",   out_valid_b, 1'b1);
    check("nomul_code",    alu_control_b, 6'b000000);
    check("nomul_illegal", illegal_b, 1'b1);
    check("nomul_ready",   in_ready_b, 1'b1);
    check("mul1_valid",    out_valid_c, 1'b1);
    check("mul1_code",     alu_control_c, 4'b0111);
    check("mul1_illegal",  illegal_c, 1'b0);
    check("mul1_ready",    in_ready_c, 1'b1);
    idle(4);

    // randomized mix
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 10'($urandom) : ftab[$urandom_range(0, 9)],
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end
    idle(5);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
